// File: rtl/lbp_scan_ctrl.sv
// lbp_scan_ctrl
//   Sequencing controller for the LBP image pipeline. Scans a W x W image
//   twice: the first pass fetches every RGB pixel and strobes the gray write,
//   the second pass revisits every pixel, fetching a 3x3 window for interior
//   pixels and strobing a zero LBP write for border pixels. Drives only
//   addresses, strobes and status; all outputs are decoded from registered
//   state, so there is no combinational input-to-output path.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      begin a frame (sampled only in IDLE and DONE)
//   rgb_req    RGB fetch request          rgb_addr   RGB pixel address
//   rgb_ready  RGB data valid, completes the request
//   gray_wen   gray write strobe          gray_addr  gray write address
//   win_req    3x3 window fetch request   win_addr   window centre address
//   win_ready  window complete
//   lbp_valid  LBP write strobe           lbp_addr   LBP write address
//   lbp_zero   qualifies lbp_valid: write 0 for a border pixel
//   busy       high outside IDLE and DONE
//   finish     frame complete, held in DONE
module lbp_scan_ctrl #(
  parameter int W  = 128,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          rgb_req,
  output logic [AW-1:0] rgb_addr,
  input  logic          rgb_ready,
  output logic          gray_wen,
  output logic [AW-1:0] gray_addr,
  output logic          win_req,
  output logic [AW-1:0] win_addr,
  input  logic          win_ready,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic          lbp_zero,
  output logic          busy,
  output logic          finish
);

  localparam int            RW       = $clog2(W);
  localparam logic [AW-1:0] LAST_PIX = AW'(W * W - 1);
  localparam logic [RW-1:0] LAST_RC  = RW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRAY_REQ,
    S_GRAY_WR,
    S_WIN_REQ,
    S_LBP_WR,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic [RW-1:0] row_nx, col_nx;
  logic          last_pix;
  logic          border_cur;
  logic          border_nx;

  function automatic logic is_border(input logic [RW-1:0] r, input logic [RW-1:0] c);
    return (r == '0) || (r == LAST_RC) || (c == '0) || (c == LAST_RC);
  endfunction

  // Row/col of the pixel after cnt; cnt itself is the linear address, so
  // row*W+col never needs a multiplier.
  always_comb begin
    if (col_q == LAST_RC) begin
      col_nx = '0;
      row_nx = row_q + RW'(1);
    end else begin
      col_nx = col_q + RW'(1);
      row_nx = row_q;
    end
  end

  assign last_pix   = (cnt_q == LAST_PIX);
  assign border_cur = is_border(row_q, col_q);
  assign border_nx  = is_border(row_nx, col_nx);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_GRAY_REQ;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_GRAY_REQ: begin
        if (rgb_ready) state_d = S_GRAY_WR;
      end
      S_GRAY_WR: begin
        if (last_pix) begin
          // Pixel 0 is always a border pixel: go straight to its LBP write.
          state_d = S_LBP_WR;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = S_GRAY_REQ;
          cnt_d   = cnt_q + AW'(1);
          row_d   = row_nx;
          col_d   = col_nx;
        end
      end
      S_WIN_REQ: begin
        if (win_ready) state_d = S_LBP_WR;
      end
      S_LBP_WR: begin
        if (last_pix) begin
          state_d = S_DONE;
        end else begin
          state_d = border_nx ? S_LBP_WR : S_WIN_REQ;
          cnt_d   = cnt_q + AW'(1);
          row_d   = row_nx;
          col_d   = col_nx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Addresses are forced to zero whenever their strobe is low.
  always_comb begin
    rgb_req   = 1'b0;
    rgb_addr  = '0;
    gray_wen  = 1'b0;
    gray_addr = '0;
    win_req   = 1'b0;
    win_addr  = '0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_zero  = 1'b0;
    busy      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      S_GRAY_REQ: begin
        rgb_req  = 1'b1;
        rgb_addr = cnt_q;
        busy     = 1'b1;
      end
      S_GRAY_WR: begin
        gray_wen  = 1'b1;
        gray_addr = cnt_q;
        busy      = 1'b1;
      end
      S_WIN_REQ: begin
        win_req  = 1'b1;
        win_addr = cnt_q;
        busy     = 1'b1;
      end
      S_LBP_WR: begin
        lbp_valid = 1'b1;
        lbp_addr  = cnt_q;
        lbp_zero  = border_cur;
        busy      = 1'b1;
      end
      S_DONE:  finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Testbench for lbp_scan_ctrl: a W=4 instance for directed frames and a
// W=128 instance for a full-size frame with random ready delays.
module tb_lbp_scan_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s4 = 1'b0, s128 = 1'b0;

  logic       u4_rgb_req, u4_gray_wen, u4_win_req, u4_lbp_valid, u4_lbp_zero, u4_busy, u4_finish;
  logic [3:0] u4_rgb_addr, u4_gray_addr, u4_win_addr, u4_lbp_addr;
  logic       u4_rgb_ready = 1'b0, u4_win_ready = 1'b0;

  logic        u128_rgb_req, u128_gray_wen, u128_win_req, u128_lbp_valid, u128_lbp_zero;
  logic        u128_busy, u128_finish;
  logic [13:0] u128_rgb_addr, u128_gray_addr, u128_win_addr, u128_lbp_addr;
  logic        u128_rgb_ready = 1'b0, u128_win_ready = 1'b0;

  logic [22:0] u4_all;
  logic        u128_any;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m4      = 3;  // 3: manual readies, 0: zero-wait, 1: directed stalls
  int m128    = 3;  // 3: manual readies, otherwise random delays
  int r4_rem = -1, w4_rem = -1, r128_rem = -1, w128_rem = -1;
  int tot128 = 0;

  int gq4[$], lq4[$], zq4[$], wq4[$];
  int ovl4 = 0, stab4 = 0, rgb7_4 = 0, win9_4 = 0, fin4 = -1, e0_4 = 0;
  logic p4_rs = 1'b0, p4_ws = 1'b0, p4_fin = 1'b0;
  logic [3:0] p4_ra = '0, p4_wa = '0;

  int gq128[$], lq128[$], zq128[$], wq128[$];
  int ovl128 = 0, stab128 = 0, fin128 = -1, e0_128 = 0;
  logic p128_rs = 1'b0, p128_ws = 1'b0, p128_fin = 1'b0;
  logic [13:0] p128_ra = '0, p128_wa = '0;

  lbp_scan_ctrl #(.W(4), .AW(4)) u4 (
    .clk(clk), .reset(reset), .start(s4),
    .rgb_req(u4_rgb_req), .rgb_addr(u4_rgb_addr), .rgb_ready(u4_rgb_ready),
    .gray_wen(u4_gray_wen), .gray_addr(u4_gray_addr),
    .win_req(u4_win_req), .win_addr(u4_win_addr), .win_ready(u4_win_ready),
    .lbp_valid(u4_lbp_valid), .lbp_addr(u4_lbp_addr), .lbp_zero(u4_lbp_zero),
    .busy(u4_busy), .finish(u4_finish)
  );

  lbp_scan_ctrl #(.W(128), .AW(14)) u128 (
    .clk(clk), .reset(reset), .start(s128),
    .rgb_req(u128_rgb_req), .rgb_addr(u128_rgb_addr), .rgb_ready(u128_rgb_ready),
    .gray_wen(u128_gray_wen), .gray_addr(u128_gray_addr),
    .win_req(u128_win_req), .win_addr(u128_win_addr), .win_ready(u128_win_ready),
    .lbp_valid(u128_lbp_valid), .lbp_addr(u128_lbp_addr), .lbp_zero(u128_lbp_zero),
    .busy(u128_busy), .finish(u128_finish)
  );

  assign u4_all = {u4_rgb_req, u4_rgb_addr, u4_gray_wen, u4_gray_addr, u4_win_req, u4_win_addr,
                   u4_lbp_valid, u4_lbp_addr, u4_lbp_zero, u4_busy, u4_finish};
  assign u128_any = |{u128_rgb_req, u128_rgb_addr, u128_gray_wen, u128_gray_addr, u128_win_req,
                      u128_win_addr, u128_lbp_valid, u128_lbp_addr, u128_lbp_zero, u128_busy,
                      u128_finish};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready responders: decide each cycle's ready just after the edge.
  always @(posedge clk) begin
    #1;
    if (m4 != 3) begin
      if (u4_rgb_req) begin
        if (r4_rem < 0) r4_rem = (m4 == 1 && u4_rgb_addr == 4'd7) ? 3 : 0;
        u4_rgb_ready = (r4_rem == 0);
        if (r4_rem > 0) r4_rem--;
      end else begin
        r4_rem = -1;
        u4_rgb_ready = 1'b1;
      end
      if (u4_win_req) begin
        if (w4_rem < 0) w4_rem = (m4 == 1 && u4_win_addr == 4'd9) ? 2 : 0;
        u4_win_ready = (w4_rem == 0);
        if (w4_rem > 0) w4_rem--;
      end else begin
        w4_rem = -1;
        u4_win_ready = 1'b1;
      end
    end
    if (m128 != 3) begin
      if (u128_rgb_req) begin
        if (r128_rem < 0) begin
          r128_rem = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
          tot128 += r128_rem;
        end
        u128_rgb_ready = (r128_rem == 0);
        if (r128_rem > 0) r128_rem--;
      end else begin
        r128_rem = -1;
        u128_rgb_ready = 1'($urandom_range(0, 1));
      end
      if (u128_win_req) begin
        if (w128_rem < 0) begin
          w128_rem = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
          tot128 += w128_rem;
        end
        u128_win_ready = (w128_rem == 0);
        if (w128_rem > 0) w128_rem--;
      end else begin
        w128_rem = -1;
        u128_win_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (u4_gray_wen) gq4.push_back(int'(u4_gray_addr));
    if (u4_lbp_valid) begin
      lq4.push_back(int'(u4_lbp_addr));
      zq4.push_back(int'(u4_lbp_zero));
    end
    if (u4_win_req && u4_win_ready) wq4.push_back(int'(u4_win_addr));
    if (u4_gray_wen && u4_lbp_valid) ovl4++;
    if (reset && p4_rs && !(u4_rgb_req && u4_rgb_addr == p4_ra)) stab4++;
    if (reset && p4_ws && !(u4_win_req && u4_win_addr == p4_wa)) stab4++;
    p4_rs = u4_rgb_req && !u4_rgb_ready;
    p4_ra = u4_rgb_addr;
    p4_ws = u4_win_req && !u4_win_ready;
    p4_wa = u4_win_addr;
    if (u4_rgb_req && u4_rgb_addr == 4'd7) rgb7_4++;
    if (u4_win_req && u4_win_addr == 4'd9) win9_4++;
    if (u4_finish && !p4_fin && fin4 < 0) fin4 = cyc;
    p4_fin = u4_finish;
  end

  always @(negedge clk) begin
    if (u128_gray_wen) gq128.push_back(int'(u128_gray_addr));
    if (u128_lbp_valid) begin
      lq128.push_back(int'(u128_lbp_addr));
      zq128.push_back(int'(u128_lbp_zero));
    end
    if (u128_win_req && u128_win_ready) wq128.push_back(int'(u128_win_addr));
    if (u128_gray_wen && u128_lbp_valid) ovl128++;
    if (reset && p128_rs && !(u128_rgb_req && u128_rgb_addr == p128_ra)) stab128++;
    if (reset && p128_ws && !(u128_win_req && u128_win_addr == p128_wa)) stab128++;
    p128_rs = u128_rgb_req && !u128_rgb_ready;
    p128_ra = u128_rgb_addr;
    p128_ws = u128_win_req && !u128_win_ready;
    p128_wa = u128_win_addr;
    if (u128_finish && !p128_fin && fin128 < 0) fin128 = cyc;
    p128_fin = u128_finish;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int frame_lat(input int w);
    return 2 * w * w + (4 * w - 4) + 2 * (w - 2) * (w - 2);
  endfunction

  // Reference frame: every pixel once in ascending order for both passes,
  // zero LBP on the image border, window fetches on interior pixels only.
  task automatic check_frame(input string tag, input int w, input int gq[$], input int lq[$],
                             input int zq[$], input int wq[$]);
    int n, exp_z, obs_z, g_bad, l_bad, z_bad, w_bad;
    int ex_w[$];
    n = w * w; exp_z = 0; obs_z = 0; g_bad = 0; l_bad = 0; z_bad = 0; w_bad = 0;
    for (int p = 0; p < n; p++) begin
      bit b;
      b = (p / w == 0) || (p / w == w - 1) || (p % w == 0) || (p % w == w - 1);
      if (b) exp_z++;
      else ex_w.push_back(p);
      if (p < gq.size() && gq[p] != p) g_bad++;
      if (p < lq.size()) begin
        if (lq[p] != p) l_bad++;
        if (zq[p] != int'(b)) z_bad++;
        obs_z += zq[p];
      end
    end
    for (int i = 0; i < ex_w.size() && i < wq.size(); i++)
      if (wq[i] != ex_w[i]) w_bad++;
    check({tag, "_gray_n"}, gq.size(), n);
    check({tag, "_gray_order"}, g_bad, 0);
    check({tag, "_lbp_n"}, lq.size(), n);
    check({tag, "_lbp_order"}, l_bad, 0);
    check({tag, "_zero_pattern"}, z_bad, 0);
    check({tag, "_zero_count"}, obs_z, exp_z);
    check({tag, "_win_n"}, wq.size(), ex_w.size());
    check({tag, "_win_addr"}, w_bad, 0);
  endtask

  task automatic clear4();
    gq4.delete(); lq4.delete(); zq4.delete(); wq4.delete();
    ovl4 = 0; stab4 = 0; rgb7_4 = 0; win9_4 = 0; fin4 = -1;
    p4_rs = 1'b0; p4_ws = 1'b0;
  endtask

  task automatic pulse4();
    @(posedge clk); #1;
    s4 = 1'b1;
    e0_4 = cyc + 1;
    @(posedge clk); #1;
    s4 = 1'b0;
  endtask

  task automatic run4(input string tag, input int exp_lat);
    for (int i = 0; i < 400 && fin4 < 0; i++) @(negedge clk);
    check({tag, "_finish_lat"}, fin4 - e0_4, exp_lat);
    check_frame(tag, 4, gq4, lq4, zq4, wq4);
    check({tag, "_overlap"}, ovl4, 0);
    check({tag, "_req_stable"}, stab4, 0);
  endtask

  initial begin
    // Reset held low with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      s4 = 1'($urandom_range(0, 1));
      s128 = 1'($urandom_range(0, 1));
      u4_rgb_ready = 1'($urandom_range(0, 1));
      u4_win_ready = 1'($urandom_range(0, 1));
      u128_rgb_ready = 1'($urandom_range(0, 1));
      u128_win_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_outputs_u4", int'(u4_all), 0);
      check("rst_outputs_u128", int'(u128_any), 0);
    end
    @(posedge clk); #1;
    reset = 1'b1; s4 = 1'b0; s128 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_outputs_u4", int'(u4_all), 0);
      check("idle_busy_u4", int'(u4_busy), 0);
      check("idle_outputs_u128", int'(u128_any), 0);
    end

    // Zero-wait frame
    m4 = 0;
    clear4();
    pulse4();
    run4("zw", frame_lat(4));
    @(negedge clk);
    check("zw_finish_held", int'(u4_finish), 1);
    check("zw_busy_done", int'(u4_busy), 0);

    // Restart from DONE
    clear4();
    pulse4();
    check("restart_finish_drop", int'(u4_finish), 0);
    check("restart_busy", int'(u4_busy), 1);
    check("restart_rgb_req", int'(u4_rgb_req), 1);
    check("restart_rgb_addr", int'(u4_rgb_addr), 0);
    run4("restart", frame_lat(4));

    // Start pulses while busy (gray pass and LBP pass) are ignored
    clear4();
    pulse4();
    repeat (8) @(posedge clk);
    #1 s4 = 1'b1;
    @(posedge clk); #1 s4 = 1'b0;
    repeat (30) @(posedge clk);
    #1 s4 = 1'b1;
    @(posedge clk); #1 s4 = 1'b0;
    run4("busy_start", frame_lat(4));

    // Backpressure: rgb stalls 3 cycles at 7, window stalls 2 cycles at 9
    m4 = 1;
    clear4();
    pulse4();
    run4("bp", frame_lat(4) + 5);
    check("bp_rgb7_cycles", rgb7_4, 4);
    check("bp_win9_cycles", win9_4, 3);

    // Asynchronous reset in the middle of the LBP pass
    m4 = 0;
    clear4();
    pulse4();
    for (int i = 0; i < 200 && lq4.size() < 7; i++) @(negedge clk);
    check("mid_reached_lbp", int'(lq4.size() >= 7), 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_async", int'(u4_all), 0);
    @(posedge clk); #1;
    check("mid_rst_held", int'(u4_all), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_idle", int'(u4_all), 0);
    clear4();
    pulse4();
    run4("replay", frame_lat(4));

    // Full-size frame with random ready delays
    m128 = 1;
    gq128.delete(); lq128.delete(); zq128.delete(); wq128.delete();
    ovl128 = 0; stab128 = 0; fin128 = -1; tot128 = 0;
    @(posedge clk); #1;
    s128 = 1'b1;
    e0_128 = cyc + 1;
    @(posedge clk); #1;
    s128 = 1'b0;
    for (int i = 0; i < 95000 && fin128 < 0; i++) @(negedge clk);
    check("full_finish_lat", fin128 - e0_128, frame_lat(128) + tot128);
    check_frame("full", 128, gq128, lq128, zq128, wq128);
    check("full_overlap", ovl128, 0);
    check("full_req_stable", stab128, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
